// File: rtl/state_sequence_monitor.sv
// Passive checker for the rotating state-sequencer indicator lines.
// Flags one-hot, ordering and dwell violations and counts completed rotations.
module state_sequence_monitor #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sIDLE,
  input  logic             s1,
  input  logic             s2,
  input  logic             s3,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] period_count
);

  localparam int unsigned DW = $clog2(DWELL + 2);
  localparam logic [DW-1:0] DWELL_V   = DW'(DWELL);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL + 1);

  typedef enum logic [2:0] {
    C_NONE,
    C_IDLE,
    C_S1,
    C_S2,
    C_S3,
    C_INV
  } code_t;

  typedef enum logic {
    HUNT,
    TRACK
  } mode_t;

  typedef enum logic [1:0] {
    E_ONEHOT = 2'b00,
    E_ORDER  = 2'b01,
    E_SHORT  = 2'b10,
    E_LONG   = 2'b11
  } err_t;

  mode_t            mode_q, mode_d;
  code_t            prev_q, prev_d;
  code_t            cur;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             exempt_q, exempt_d;
  logic             locked_q;
  logic             err_valid_q;
  err_t             err_code_q;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_d;
  err_t             code_d;
  logic             inc;
  logic             legal_step;

  always_comb begin
    case ({sIDLE, s1, s2, s3})
      4'b1000: cur = C_IDLE;
      4'b0100: cur = C_S1;
      4'b0010: cur = C_S2;
      4'b0001: cur = C_S3;
      default: cur = C_INV;
    endcase
  end

  assign legal_step = ((prev_q == C_S1) && (cur == C_S2)) ||
                      ((prev_q == C_S2) && (cur == C_S3)) ||
                      ((prev_q == C_S3) && (cur == C_S1));

  always_comb begin
    if (cur == C_INV) begin
      dwell_d = '0;
    end else if (cur == prev_q) begin
      dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
    end else begin
      dwell_d = DW'(1);
    end
  end

  // Check order inside the TRACK branch gives 00 > 01 > 10/11 priority.
  always_comb begin
    mode_d   = mode_q;
    prev_d   = (cur == C_INV) ? C_NONE : cur;
    exempt_d = exempt_q;
    err_d    = 1'b0;
    code_d   = E_ONEHOT;
    inc      = 1'b0;

    if (cur == C_INV) begin
      err_d    = 1'b1;
      code_d   = E_ONEHOT;
      mode_d   = HUNT;
      exempt_d = 1'b0;
    end else if (mode_q == TRACK) begin
      if (cur != prev_q) begin
        exempt_d = 1'b0;
        if (cur == C_IDLE) begin
          mode_d = HUNT;
        end else if (!legal_step) begin
          err_d  = 1'b1;
          code_d = E_ORDER;
          mode_d = HUNT;
        end else if ((dwell_q < DWELL_V) && !exempt_q) begin
          err_d  = 1'b1;
          code_d = E_SHORT;
          mode_d = HUNT;
        end else if (prev_q == C_S3) begin
          inc = 1'b1;
        end
      end else if (dwell_q == DWELL_V) begin
        err_d  = 1'b1;
        code_d = E_LONG;
        mode_d = HUNT;
      end
    end else if ((cur == C_S1) && ((prev_q == C_IDLE) || (prev_q == C_S3))) begin
      // The entry S1 may already be part-way through its dwell.
      mode_d   = TRACK;
      exempt_d = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  assign err_sticky_d = err_d | (err_sticky_q & ~clr_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= HUNT;
      prev_q       <= C_NONE;
      dwell_q      <= '0;
      exempt_q     <= 1'b0;
      locked_q     <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= E_ONEHOT;
      err_sticky_q <= 1'b0;
      count_q      <= '0;
    end else begin
      mode_q       <= mode_d;
      prev_q       <= prev_d;
      dwell_q      <= dwell_d;
      exempt_q     <= exempt_d;
      locked_q     <= (mode_d == TRACK);
      err_valid_q  <= err_d;
      err_code_q   <= err_d ? code_d : E_ONEHOT;
      err_sticky_q <= err_sticky_d;
      count_q      <= count_d;
    end
  end

  assign locked       = locked_q;
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign err_sticky   = err_sticky_q;
  assign period_count = count_q;

endmodule

// File: tb/tb_state_sequence_monitor.sv
// Directed scoreboard bench for state_sequence_monitor (DWELL=4), with a
// CNT_W=2 twin on the same inputs to observe counter saturation.
module tb_state_sequence_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sIDLE, s1, s2, s3, clr_err;
  logic        locked, err_valid, err_sticky;
  logic [1:0]  err_code;
  logic [15:0] period_count;
  logic        locked2, err_valid2, err_sticky2;
  logic [1:0]  err_code2;
  logic [1:0]  period_count2;

  state_sequence_monitor #(.DWELL(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sIDLE(sIDLE), .s1(s1), .s2(s2), .s3(s3),
    .clr_err(clr_err), .locked(locked), .err_valid(err_valid),
    .err_code(err_code), .err_sticky(err_sticky), .period_count(period_count)
  );

  state_sequence_monitor #(.DWELL(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sIDLE(sIDLE), .s1(s1), .s2(s2), .s3(s3),
    .clr_err(clr_err), .locked(locked2), .err_valid(err_valid2),
    .err_code(err_code2), .err_sticky(err_sticky2), .period_count(period_count2)
  );

  localparam logic [3:0] NO = 4'b0000;
  localparam logic [3:0] I  = 4'b1000;
  localparam logic [3:0] A  = 4'b0100;
  localparam logic [3:0] B  = 4'b0010;
  localparam logic [3:0] C  = 4'b0001;
  localparam logic [3:0] AB = 4'b0110;

  typedef struct {
    logic        lk;
    logic        ev;
    logic [1:0]  ec;
    logic        st;
    logic [15:0] pc;
    logic [1:0]  pc2;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic c,
                      input logic lk, input logic ev, input logic [1:0] ec,
                      input logic st, input int pc, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    {sIDLE, s1, s2, s3} = v;
    clr_err = c;
    e.lk  = lk;
    e.ev  = ev;
    e.ec  = ec;
    e.st  = st;
    e.pc  = 16'(pc);
    e.pc2 = (pc > 3) ? 2'd3 : 2'(pc);
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".locked"},     16'(locked),        16'(e.lk));
    chk({e.tag, ".err_valid"},  16'(err_valid),     16'(e.ev));
    chk({e.tag, ".err_code"},   16'(err_code),      16'(e.ec));
    chk({e.tag, ".err_sticky"}, 16'(err_sticky),    16'(e.st));
    chk({e.tag, ".count"},      period_count,       e.pc);
    chk({e.tag, ".count_w2"},   16'(period_count2), 16'(e.pc2));
  endtask

  task automatic clean(input logic [3:0] v, input int n, input logic lk,
                       input logic st, input int pc, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, v, 1'b0, lk, 1'b0, 2'b00, st, pc, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; {sIDLE, s1, s2, s3} = NO; clr_err = 1'b0;

    step(1'b1, NO, 1'b0, 0, 0, 2'b00, 0, 0, "reset");
    step(1'b1, A,  1'b0, 0, 0, 2'b00, 0, 0, "reset_hold");

    // Three clean rotations plus the closing S1.
    clean(I, 1, 0, 0, 0, "idle");
    for (int r = 0; r < 3; r++) begin
      clean(A, 4, 1, 0, r, "rot_s1");
      clean(B, 4, 1, 0, r, "rot_s2");
      clean(C, 4, 1, 0, r, "rot_s3");
    end
    clean(A, 1, 1, 0, 3, "rot_close");

    // Short dwell in S2, then re-lock through S3 -> S1.
    clean(A, 3, 1, 0, 3, "pre_short_s1");
    clean(B, 2, 1, 0, 3, "short_s2");
    step(1'b0, C, 1'b0, 0, 1, 2'b10, 1, 3, "dwell_short");
    clean(C, 3, 0, 1, 3, "hunt_s3");
    clean(A, 4, 1, 1, 3, "relock_s1");

    // Long dwell in S2: exactly one pulse on the 5th sample.
    clean(B, 4, 1, 1, 3, "long_s2");
    step(1'b0, B, 1'b0, 0, 1, 2'b11, 1, 3, "dwell_long");
    clean(B, 3, 0, 1, 3, "long_hold");

    // Illegal order, then one-hot faults with clr_err interplay.
    clean(C, 1, 0, 1, 3, "resync_s3");
    clean(A, 4, 1, 1, 3, "order_s1");
    step(1'b0, C,  1'b0, 0, 1, 2'b01, 1, 3, "order_err");
    step(1'b0, C,  1'b1, 0, 0, 2'b00, 0, 3, "clr_first");
    step(1'b0, A,  1'b0, 1, 0, 2'b00, 0, 3, "lock_again");
    step(1'b0, AB, 1'b1, 0, 1, 2'b00, 1, 3, "multi_hot_with_clr");
    step(1'b0, A,  1'b1, 0, 0, 2'b00, 0, 3, "clr_alone");
    step(1'b0, A,  1'b0, 0, 0, 2'b00, 0, 3, "no_lock_after_inv");
    step(1'b0, NO, 1'b0, 0, 1, 2'b00, 1, 3, "zero_hot");
    step(1'b0, I,  1'b1, 0, 0, 2'b00, 0, 3, "clr_idle");

    // Fourth rotation, IDLE drop, then reset mid-S2.
    clean(A, 4, 1, 0, 3, "r4_s1");
    clean(B, 4, 1, 0, 3, "r4_s2");
    clean(C, 4, 1, 0, 3, "r4_s3");
    clean(A, 4, 1, 0, 4, "r4_close");
    step(1'b0, I, 1'b0, 0, 0, 2'b00, 0, 4, "idle_drop");
    clean(A, 4, 1, 0, 4, "pre_rst_s1");
    clean(B, 2, 1, 0, 4, "pre_rst_s2");
    step(1'b1, B, 1'b0, 0, 0, 2'b00, 0, 0, "rst_mid");

    // After reset: no lock without IDLE/S3, entry-S1 exemption, order over short.
    step(1'b0, A, 1'b0, 0, 0, 2'b00, 0, 0, "no_lock_after_rst");
    clean(I, 1, 0, 0, 0, "post_rst_idle");
    clean(A, 2, 1, 0, 0, "exempt_s1");
    clean(B, 4, 1, 0, 0, "exempt_s2");
    clean(C, 4, 1, 0, 0, "exempt_s3");
    clean(A, 4, 1, 0, 1, "pri_s1");
    clean(B, 2, 1, 0, 1, "pri_s2");
    step(1'b0, A, 1'b0, 0, 1, 2'b01, 1, 1, "order_over_short");

    // Five rotations: 16-bit counter reaches 5, 2-bit twin holds at 3.
    step(1'b1, NO, 1'b0, 0, 0, 2'b00, 0, 0, "rst_sat");
    clean(I, 1, 0, 0, 0, "sat_idle");
    for (int r = 0; r < 5; r++) begin
      clean(A, 4, 1, 0, r, "sat_s1");
      clean(B, 4, 1, 0, r, "sat_s2");
      clean(C, 4, 1, 0, r, "sat_s3");
    end
    clean(A, 1, 1, 0, 5, "sat_close");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
